// File: rtl/car_sprite_fetch.sv
// Sprite fetch stage: raster/car position -> sprite ROM address, hit realigned with ROM data, RGB565->888 out.
// Optional horizontal flip via `define SPRITE_MIRROR_EN (adds mirror_x, shadowed at frame_start).
module car_sprite_fetch #(
    parameter int         SPR_W  = 32,
    parameter int         SPR_H  = 64,
    parameter int         ADDR_W = 11,
    parameter int         RD_LAT = 1,
    parameter logic [9:0] INIT_X = 10'd200,
    parameter logic [9:0] INIT_Y = 10'd400
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pixel_valid,
    input  logic              frame_start,
    input  logic [9:0]        car_x,
    input  logic [9:0]        car_y,
`ifdef SPRITE_MIRROR_EN
    input  logic              mirror_x,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       onchip_data,
    input  logic              is_background,
    output logic              sprite_on,
    output logic [23:0]       sprite_rgb
);

    localparam int XB = $clog2(SPR_W);
    localparam int YB = ADDR_W - XB;

    logic [9:0]        pos_x, pos_y;
    logic [10:0]       x_lo, x_hi, y_lo, y_hi;
    logic              in_x, in_y, hit_c;
    logic [XB-1:0]     x_off;
    logic [YB-1:0]     y_off;
    logic [ADDR_W-1:0] addr_c;
    logic              hit0;
    logic [RD_LAT-1:0] hit_sr;
    logic              hit_d;
    logic [4:0]        r5, b5;
    logic [5:0]        g6;

    // Positions only move at frame_start so a frame is never drawn with two positions.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pos_x <= INIT_X;
            pos_y <= INIT_Y;
        end else if (frame_start) begin
            pos_x <= car_x;
            pos_y <= car_y;
        end
    end

`ifdef SPRITE_MIRROR_EN
    logic mirror_q;

    always_ff @(posedge Clk) begin
        if (Reset)
            mirror_q <= 1'b0;
        else if (frame_start)
            mirror_q <= mirror_x;
    end
`endif

    always_comb begin
        // 11-bit bounds keep a sprite near the right/bottom edge from wrapping.
        x_lo  = {1'b0, pos_x};
        x_hi  = x_lo + 11'(SPR_W);
        y_lo  = {1'b0, pos_y};
        y_hi  = y_lo + 11'(SPR_H);
        in_x  = ({1'b0, DrawX} >= x_lo) && ({1'b0, DrawX} < x_hi);
        in_y  = ({1'b0, DrawY} >= y_lo) && ({1'b0, DrawY} < y_hi);
        hit_c = pixel_valid && in_x && in_y;
        x_off = DrawX[XB-1:0] - pos_x[XB-1:0];
        y_off = DrawY[YB-1:0] - pos_y[YB-1:0];
`ifdef SPRITE_MIRROR_EN
        if (mirror_q)
            x_off = XB'(SPR_W - 1) - (DrawX[XB-1:0] - pos_x[XB-1:0]);
`endif
        addr_c = {y_off, x_off};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit0     <= 1'b0;
            rom_addr <= '0;
        end else begin
            hit0     <= hit_c;
            rom_addr <= hit_c ? addr_c : '0;
        end
    end

    // Delay the hit flag by the ROM read latency so it lines up with rom_data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit_sr <= '0;
        end else begin
            hit_sr[0] <= hit0;
            for (int i = 1; i < RD_LAT; i++)
                hit_sr[i] <= hit_sr[i-1];
        end
    end

    always_comb begin
        hit_d       = hit_sr[RD_LAT-1];
        onchip_data = hit_d ? rom_data : 16'h0000;
        r5          = onchip_data[15:11];
        g6          = onchip_data[10:5];
        b5          = onchip_data[4:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sprite_on  <= 1'b0;
            sprite_rgb <= 24'h0;
        end else begin
            sprite_on  <= hit_d && !is_background;
            sprite_rgb <= hit_d ? {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]} : 24'h0;
        end
    end

endmodule

// File: tb/tb_car_sprite_fetch.sv
// Bench for car_sprite_fetch: vector table, hand sequences and random raster against a position-based model.
module tb_car_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY, car_x, car_y;
    logic        pixel_valid, frame_start, mirror_x;
    logic [10:0] rom_addr;
    logic [15:0] rom_data, onchip_data;
    logic        is_background, sprite_on;
    logic [23:0] sprite_rgb;

    logic [15:0] mem [0:2047];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: shadowed position plus the last two sampled pixels.
    int m_px, m_py;
    bit m_mir;
    bit h1, h2;
    int a1, a2;

    always #5 Clk = ~Clk;

    car_sprite_fetch dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .pixel_valid(pixel_valid), .frame_start(frame_start),
        .car_x(car_x), .car_y(car_y),
`ifdef SPRITE_MIRROR_EN
        .mirror_x(mirror_x),
`endif
        .rom_addr(rom_addr), .rom_data(rom_data), .onchip_data(onchip_data),
        .is_background(is_background), .sprite_on(sprite_on), .sprite_rgb(sprite_rgb)
    );

    always @(posedge Clk) rom_data <= mem[rom_addr];
    assign is_background = (onchip_data == 16'hFFFF);

    function automatic logic [31:0] rgb888(input int d);
        int r, g, b;
        r = (d >> 11) & 31;
        g = (d >> 5) & 63;
        b = d & 31;
        return 32'((((r << 3) | (r >> 2)) << 16) | (((g << 2) | (g >> 4)) << 8) | ((b << 3) | (b >> 2)));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One pixel per call: drive at negedge, step one clock, check at the next negedge.
    task automatic cyc(input logic [9:0] x, input logic [9:0] y, input logic pv, input logic fs,
                       input logic [9:0] cx, input logic [9:0] cy, input logic rst);
        bit h;
        int a, dx, dy;
        DrawX = x; DrawY = y; pixel_valid = pv; frame_start = fs;
        car_x = cx; car_y = cy; Reset = rst;
        dx = int'(x) - m_px;
        dy = int'(y) - m_py;
        h  = pv && dx >= 0 && dx < 32 && dy >= 0 && dy < 64 && !rst;
        a  = h ? dy * 32 + (m_mir ? 31 - dx : dx) : 0;
        if (rst) begin
            m_px = 200; m_py = 400; m_mir = 0;
            h1 = 0; h2 = 0;
        end else if (fs) begin
            m_px = int'(cx); m_py = int'(cy); m_mir = mirror_x;
        end
        @(posedge Clk);
        @(negedge Clk);
        check("rom_addr", 32'(rom_addr), 32'(a));
        check("onchip_data", 32'(onchip_data), h1 ? 32'(mem[a1]) : 32'h0);
        check("sprite_on", 32'(sprite_on), 32'(h2 && mem[a2] != 16'hFFFF));
        check("sprite_rgb", 32'(sprite_rgb), h2 ? rgb888(int'(mem[a2])) : 32'h0);
        h2 = h1; a2 = a1;
        h1 = h;  a1 = a;
    endtask

    task automatic idle();
        cyc(10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        pv;
        logic [10:0] exp_addr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{10'd100, 10'd50,  1'b1, 11'd0};
        tbl[1] = '{10'd131, 10'd113, 1'b1, 11'd2047};
        tbl[2] = '{10'd132, 10'd113, 1'b1, 11'd0};
        tbl[3] = '{10'd131, 10'd114, 1'b1, 11'd0};
        tbl[4] = '{10'd99,  10'd50,  1'b1, 11'd0};
        tbl[5] = '{10'd115, 10'd60,  1'b1, 11'd335};
        tbl[6] = '{10'd100, 10'd50,  1'b0, 11'd0};
        tbl[7] = '{10'd105, 10'd50,  1'b1, 11'd5};

        for (int i = 0; i < 2048; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        mem[0] = 16'h001F;
        mem[5] = 16'hFFFF;
        m_px = 200; m_py = 400; m_mir = 0;
        h1 = 0; h2 = 0; a1 = 0; a2 = 0;
        mirror_x = 1'b0;
        Reset = 1'b1; DrawX = '0; DrawY = '0; pixel_valid = 1'b0; frame_start = 1'b0;
        car_x = '0; car_y = '0;
        @(negedge Clk);

        // Reset state, then first frame_start moves the car to (100,50) from the next cycle.
        cyc(10'd100, 10'd50, 1'b1, 1'b0, 10'd0, 10'd0, 1'b1);
        cyc(10'd100, 10'd50, 1'b1, 1'b0, 10'd0, 10'd0, 1'b1);
        check("reset_sprite_on", 32'(sprite_on), 32'h0);
        check("reset_rom_addr", 32'(rom_addr), 32'h0);
        cyc(10'd100, 10'd50, 1'b1, 1'b1, 10'd100, 10'd50, 1'b0);
        check("old_pos_miss", 32'(rom_addr), 32'h0);

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].x, tbl[i].y, tbl[i].pv, 1'b0, 10'd0, 10'd0, 1'b0);
            check("tbl_addr", 32'(rom_addr), 32'(tbl[i].exp_addr));
        end
        idle(); idle();

        // Opaque blue pixel, then a background-keyed white pixel.
        cyc(10'd100, 10'd50, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        idle(); idle();
        check("blue_on", 32'(sprite_on), 32'h1);
        check("blue_rgb", 32'(sprite_rgb), 32'h0000FF);
        cyc(10'd105, 10'd50, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        idle(); idle();
        check("bg_on", 32'(sprite_on), 32'h0);
        check("bg_rgb", 32'(sprite_rgb), 32'hFFFFFF);

        // Reset with pixels in flight.
        cyc(10'd100, 10'd50, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        cyc(10'd101, 10'd50, 1'b1, 1'b0, 10'd0, 10'd0, 1'b1);
        check("midrst_on", 32'(sprite_on), 32'h0);
        check("midrst_rgb", 32'(sprite_rgb), 32'h0);
        idle();

        // Right-edge placement: pos_x+SPR_W exceeds 1023 without wrapping.
        cyc(10'd0, 10'd0, 1'b0, 1'b1, 10'd1000, 10'd50, 1'b0);
        cyc(10'd1010, 10'd60, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        check("edge_hit", 32'(rom_addr), 32'd330);
        cyc(10'd1023, 10'd60, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        check("edge_last", 32'(rom_addr), 32'd343);
        cyc(10'd1010, 10'd60, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        check("edge_pv0", 32'(rom_addr), 32'd0);

        // car_x changes mid-frame are ignored; frame_start on a hit uses the old position.
        cyc(10'd1010, 10'd60, 1'b1, 1'b0, 10'd500, 10'd20, 1'b0);
        check("no_tear", 32'(rom_addr), 32'd330);
        cyc(10'd1010, 10'd60, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
        check("fs_old_pos", 32'(rom_addr), 32'd330);
        cyc(10'd5, 10'd3, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        check("fs_new_pos", 32'(rom_addr), 32'd101);

`ifdef SPRITE_MIRROR_EN
        mirror_x = 1'b1;
        cyc(10'd0, 10'd0, 1'b0, 1'b1, 10'd100, 10'd50, 1'b0);
        mirror_x = 1'b0;
        cyc(10'd100, 10'd50, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
        check("mirror_addr", 32'(rom_addr), 32'd31);
`endif

        // Random raster around the car with occasional repositioning and reset.
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] rx, ry, rcx, rcy;
            logic rfs, rrst, rpv;
            rfs  = ($urandom_range(0, 31) == 0);
            rrst = ($urandom_range(0, 499) == 0);
            rpv  = ($urandom_range(0, 7) != 0);
            rcx  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
            rcy  = 10'($urandom_range(0, 1023));
            rx   = 10'(m_px + int'($urandom_range(0, 47)) - 8);
            ry   = 10'(m_py + int'($urandom_range(0, 79)) - 8);
`ifdef SPRITE_MIRROR_EN
            mirror_x = 1'($urandom_range(0, 1));
`endif
            cyc(rx, ry, rpv, rfs, rcx, rcy, rrst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/car_sprite_fetch.md
Name: car_sprite_fetch

Overview:
Per-pixel sprite fetch stage that sits directly upstream of the sprite background-colour checker. From the VGA raster position and the car position, it generates the on-chip sprite ROM address and realigns the returned RGB565 word with its hit flag. It drives that word to the checker as onchip_data, takes back is_background, and registers a final sprite_on/sprite_rgb pair for the colour mapper.

Parameters:
SPR_W, 32, sprite width in pixels (power of two)
SPR_H, 64, sprite height in pixels
ADDR_W, 11, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
RD_LAT, 1, on-chip ROM read latency in cycles (1 or 2)
INIT_X, 10'd200, car X position after reset
INIT_Y, 10'd400, car Y position after reset

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
DrawX  in  10  current raster column
DrawY  in  10  current raster row
pixel_valid  in  1  high during the active display region
frame_start  in  1  one-cycle pulse at the start of vertical blank
car_x  in  10  requested car left edge (game logic)
car_y  in  10  requested car top edge (game logic)
rom_addr  out  ADDR_W  sprite ROM read address
rom_data  in  16  ROM read data, valid RD_LAT cycles after rom_addr
onchip_data  out  16  aligned RGB565 word to the background checker
is_background  in  1  combinational answer from the checker for onchip_data
sprite_on  out  1  sprite pixel is opaque at this pipeline slot
sprite_rgb  out  24  RGB888 expansion of the aligned pixel

Behaviour:
- Reset is synchronous and active-high and applies on Clk. It clears the hit delay line, rom_addr, sprite_on and sprite_rgb to 0, and loads pos_x/pos_y shadow registers with INIT_X/INIT_Y.
- Position shadowing: when frame_start=1, pos_x<=car_x and pos_y<=car_y on that edge. Positions are otherwise held, so no tearing occurs mid-frame.
- Stage 0 (registered):
  - hit0 = pixel_valid & (DrawX>=pos_x) & (DrawX<pos_x+SPR_W) & (DrawY>=pos_y) & (DrawY<pos_y+SPR_H).
  - All compares use 11-bit zero-extended sums, so pos_x+SPR_W>1023 does not wrap.
  - On hit0, rom_addr <= (DrawY-pos_y)*SPR_W + (DrawX-pos_x), computed as a shift-and-concatenate since SPR_W is a power of two.
  - On miss, rom_addr <= 0.
- Hit delay line: a shift register of RD_LAT stages. hit_d is hit0 delayed RD_LAT cycles after rom_addr is registered, so it coincides with rom_data.
- onchip_data = hit_d ? rom_data : 16'h0000 (combinational from rom_data).
- Final stage (registered):
  - sprite_on <= hit_d & ~is_background.
  - sprite_rgb <= {R5,R5[4:2], G6,G6[5:4], B5,B5[4:2]} of onchip_data when hit_d, else 24'h0.
- Total latency: DrawX/DrawY sampled at edge t appear on sprite_on/sprite_rgb after edge t+RD_LAT+1, i.e. 2 cycles for RD_LAT=1. The colour mapper delays the raster by the same amount.
- Pipeline throughput: one pixel per cycle, no stalls, no back-pressure.
- Boundaries:
  - Pixel at DrawX=pos_x+SPR_W-1 hits. Pixel at pos_x+SPR_W misses. The same rule applies in Y.
  - Sprite partially off-screen: only on-screen pixels hit; the address stays consistent with the on-screen offset.
  - pixel_valid=0 forces a miss regardless of coordinates.
  - frame_start coincident with a hit: the current pixel uses the old position; the new position applies from the next cycle.
  - Reset mid-frame: outputs read 0 on the cycle after the reset edge; in-flight pixels are discarded.

Optional Feature:
SPRITE_MIRROR_EN:
- Defined: adds input port mirror_x (1 bit), shadowed at frame_start like the position. When the shadowed bit is 1, the X offset becomes SPR_W-1-(DrawX-pos_x); the hit test is unchanged.
- Undefined: no mirror_x port and no mirroring logic; the address is always unmirrored.

Test Plan:
1. Reset with Clk running -> sprite_on=0, rom_addr=0; first frame_start with car_x=100, car_y=50 updates the position on the next cycle.
2. pos=(100,50), DrawX=100, DrawY=50, pixel_valid=1 -> rom_addr=0 after 1 cycle; sprite_on=1 after 2 cycles when ROM returns 16'h001F and is_background=0; sprite_rgb=24'h0000FF.
3. DrawX=131, DrawY=113 -> rom_addr=63*32+31=2047, hit; DrawX=132 -> miss, sprite_on=0, rom_addr=0.
4. ROM returns 16'hFFFF with checker is_background=1 on a hit -> sprite_on=0 and sprite_rgb=24'hFFFFFF in the same slot.
5. pos_x=1000, DrawX=1010 -> hit, address offset 10; pixel_valid=0 at the same coordinates -> no hit.
6. car_x changes mid-frame without frame_start -> address pattern unchanged until the next frame_start pulse. With SPRITE_MIRROR_EN defined, mirror_x=1, DrawX=pos_x -> rom_addr offset 31.
